// File: rtl/map_pkg.sv
// Shared widths, sprite codes and FSM encoding for the map access path.
// Imported by the arbiter and anything that decodes its debug state.
package map_pkg;

   localparam int MAP_ADDR_W = 9;
   localparam int MAP_DATA_W = 3;

   localparam logic [MAP_DATA_W-1:0] SPR_EMPTY  = 3'd0;
   localparam logic [MAP_DATA_W-1:0] SPR_WALL   = 3'd1;
   localparam logic [MAP_DATA_W-1:0] SPR_DOT    = 3'd2;
   localparam logic [MAP_DATA_W-1:0] SPR_PACMAN = 3'd3;
   localparam logic [MAP_DATA_W-1:0] SPR_GHOST  = 3'd4;

   localparam int ST_W = 3;
   localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [ST_W-1:0] ST_READ  = 3'd1;
   localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
   localparam logic [ST_W-1:0] ST_RESP  = 3'd3;
   localparam logic [ST_W-1:0] ST_WRITE = 3'd4;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request at or above the
// pointer, wrapping past the top index back to 0.
module rr_priority_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   int unsigned w_pos;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      w_pos    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_pos = (int'(i_ptr) + k) % NUM_REQ;
         if (!o_any && i_req[w_pos]) begin
            o_any           = 1'b1;
            o_idx           = w_pos[IDX_W-1:0];
            o_onehot[w_pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/map_access_arbiter.sv
// Grants one character controller at a time an atomic read-modify-write of
// one map cell: arbitrate, read, wait RD_LAT, return data, write back.
module map_access_arbiter
   import map_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = MAP_ADDR_W,
   parameter int DATA_W  = MAP_DATA_W,
   parameter int RD_LAT  = 1
) (
   input  logic                      clock_50,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ-1:0]        req_wen,
   output logic [NUM_REQ-1:0]        grant,
   output logic [DATA_W-1:0]         rdata,
   output logic                      rdata_valid,
   output logic [NUM_REQ-1:0]        done,
   output logic [ADDR_W-1:0]         map_address,
   output logic                      map_read,
   output logic                      map_write,
   output logic [DATA_W-1:0]         map_data_out,
   input  logic [DATA_W-1:0]         map_data_in,
   output logic [ST_W-1:0]           dbg_state
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   logic [ST_W-1:0]    r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]  r_addr;
   logic [CNT_W-1:0]   r_wait_cnt;
   logic [DATA_W-1:0]  r_rdata;

   logic [NUM_REQ-1:0] w_win_onehot;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_win_any;
   logic [ADDR_W-1:0]  w_win_addr;
   logic [IDX_W-1:0]   w_next_ptr;
   logic [NUM_REQ-1:0] w_idx_onehot;
   logic               w_busy;
   logic               w_in_write;
   logic               w_req_idx;
   logic               w_wen_idx;
   logic [DATA_W-1:0]  w_wdata_idx;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_onehot (w_win_onehot),
      .o_idx    (w_win_idx),
      .o_any    (w_win_any)
   );

   assign w_win_addr   = req_addr[w_win_idx*ADDR_W +: ADDR_W];
   assign w_next_ptr   = (w_win_idx == LAST_IDX) ? '0 : w_win_idx + 1'b1;
   assign w_idx_onehot = NUM_REQ'(1) << r_idx;
   assign w_req_idx    = req[r_idx];
   assign w_wen_idx    = req_wen[r_idx];
   assign w_wdata_idx  = req_wdata[r_idx*DATA_W +: DATA_W];

   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_ptr      <= '0;
         r_addr     <= '0;
         r_wait_cnt <= '0;
         r_rdata    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_win_any) begin
                  r_idx   <= w_win_idx;
                  r_addr  <= w_win_addr;
                  r_ptr   <= w_next_ptr;
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               r_wait_cnt <= WAIT_LOAD;
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               // RAM data is only guaranteed on the final wait cycle.
               if (r_wait_cnt == '0) begin
                  r_rdata <= map_data_in;
                  r_state <= ST_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 1'b1;
               end
            end
            ST_RESP:  r_state <= ST_WRITE;
            ST_WRITE: r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode straight from state so reset clears them without a clock.
   assign w_busy       = (r_state != ST_IDLE);
   assign w_in_write   = (r_state == ST_WRITE);
   assign grant        = w_busy ? w_idx_onehot : '0;
   assign map_address  = w_busy ? r_addr : '0;
   assign map_read     = (r_state == ST_READ);
   assign map_write    = w_in_write && w_wen_idx && w_req_idx;
   assign map_data_out = w_in_write ? w_wdata_idx : '0;
   assign done         = w_in_write ? w_idx_onehot : '0;
   assign rdata_valid  = (r_state == ST_RESP);
   assign rdata        = r_rdata;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Directed bench for map_access_arbiter: two instances (RD_LAT=1 and 3),
// each backed by a small behavioural map RAM.
module tb_map_access_arbiter;
   import map_pkg::*;

   localparam int N  = 4;
   localparam int AW = 9;
   localparam int DW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // instance A: RD_LAT=1
   logic [N-1:0]    a_req = '0, a_wen = '0;
   logic [N*AW-1:0] a_addr = '0;
   logic [N*DW-1:0] a_wdata = '0;
   logic [N-1:0]    a_grant, a_done;
   logic [DW-1:0]   a_rdata, a_mdo, a_mdi;
   logic            a_rv, a_mr, a_mw;
   logic [AW-1:0]   a_maddr;
   logic [ST_W-1:0] a_st;

   // instance B: RD_LAT=3
   logic [N-1:0]    b_req = '0, b_wen = '0;
   logic [N*AW-1:0] b_addr = '0;
   logic [N*DW-1:0] b_wdata = '0;
   logic [N-1:0]    b_grant, b_done;
   logic [DW-1:0]   b_rdata, b_mdo, b_mdi;
   logic            b_rv, b_mr, b_mw;
   logic [AW-1:0]   b_maddr;
   logic [ST_W-1:0] b_st;

   map_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
      .clock_50(clk), .reset(rst), .req(a_req), .req_addr(a_addr),
      .req_wdata(a_wdata), .req_wen(a_wen), .grant(a_grant), .rdata(a_rdata),
      .rdata_valid(a_rv), .done(a_done), .map_address(a_maddr), .map_read(a_mr),
      .map_write(a_mw), .map_data_out(a_mdo), .map_data_in(a_mdi), .dbg_state(a_st)
   );

   map_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
      .clock_50(clk), .reset(rst), .req(b_req), .req_addr(b_addr),
      .req_wdata(b_wdata), .req_wen(b_wen), .grant(b_grant), .rdata(b_rdata),
      .rdata_valid(b_rv), .done(b_done), .map_address(b_maddr), .map_read(b_mr),
      .map_write(b_mw), .map_data_out(b_mdo), .map_data_in(b_mdi), .dbg_state(b_st)
   );

   // behavioural RAMs with a preload port so only one process writes them
   logic [DW-1:0] mem_a [0:511];
   logic [DW-1:0] mem_b [0:511];
   logic          pl_a = 1'b0, pl_b = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;
   logic [DW-1:0] a_q = '0, b_q = '0;
   assign a_mdi = a_q;
   assign b_mdi = b_q;

   always @(posedge clk) begin
      if (pl_a) mem_a[pl_addr] <= pl_data;
      else if (a_mw) mem_a[a_maddr] <= a_mdo;
      if (a_mr) a_q <= mem_a[a_maddr];
      if (pl_b) mem_b[pl_addr] <= pl_data;
      else if (b_mw) mem_b[b_maddr] <= b_mdo;
      if (b_mr) b_q <= mem_b[b_maddr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic preload(input logic sel_b, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      pl_addr = ad;
      pl_data = d;
      pl_a    = ~sel_b;
      pl_b    = sel_b;
      step();
      pl_a = 1'b0;
      pl_b = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      step();
   endtask

   initial begin
      // reset state
      #3;
      check("rst_grant", a_grant, 0);
      check("rst_map_read", a_mr, 0);
      check("rst_map_write", a_mw, 0);
      check("rst_rdata", a_rdata, 0);
      check("rst_state", a_st, ST_IDLE);
      step();
      rst = 1'b0;
      step();

      // single access, RD_LAT=1
      preload(1'b0, 9'd37, SPR_DOT);
      a_addr[0*AW +: AW] = 9'd37;
      a_wdata[0*DW +: DW] = SPR_PACMAN;
      a_wen = 4'b0001;
      a_req = 4'b0001;
      step();  // t+1
      check("t1_map_read", a_mr, 1);
      check("t1_addr", a_maddr, 37);
      check("t1_grant", a_grant, 4'b0001);
      step();  // t+2
      check("t2_map_read", a_mr, 0);
      check("t2_addr", a_maddr, 37);
      step();  // t+3
      check("t3_rvalid", a_rv, 1);
      check("t3_rdata", a_rdata, SPR_DOT);
      step();  // t+4
      check("t4_map_write", a_mw, 1);
      check("t4_wdata", a_mdo, SPR_PACMAN);
      check("t4_done", a_done, 4'b0001);
      check("t4_no_read", a_mr, 0);
      step();  // IDLE
      a_req = '0;
      check("t5_idle_grant", a_grant, 0);
      check("ram37", mem_a[37], SPR_PACMAN);

      // contention from fresh pointer
      do_reset();
      a_wen = '0;
      a_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("cont%0d_grant", k), a_grant, 32'(4'b0001 << (k % 4)));
         end
         step();
         check($sformatf("cont%0d_idle", k), a_st, ST_IDLE);
         check($sformatf("cont%0d_gap", k), a_grant, 0);
         if (k == 4) a_req = '0;
      end

      // read-only requester 1
      do_reset();
      preload(1'b0, 9'd100, SPR_GHOST);
      a_addr[1*AW +: AW] = 9'd100;
      a_wen = 4'b0000;
      a_req = 4'b0010;
      step();
      check("ro_grant", a_grant, 4'b0010);
      step();
      step();
      check("ro_rvalid", a_rv, 1);
      check("ro_rdata", a_rdata, SPR_GHOST);
      step();
      check("ro_map_write", a_mw, 0);
      check("ro_done", a_done, 4'b0010);
      step();
      a_req = '0;

      // dropout of requester 2 during WAIT
      preload(1'b0, 9'd200, SPR_DOT);
      a_addr[2*AW +: AW] = 9'd200;
      a_wdata[2*DW +: DW] = SPR_WALL;
      a_wen = 4'b0100;
      a_req = 4'b0100;
      step();  // READ
      check("drop_grant", a_grant, 4'b0100);
      step();  // WAIT
      a_req = '0;
      check("drop_wait_state", a_st, ST_WAIT);
      step();  // RESP
      step();  // WRITE
      check("drop_map_write", a_mw, 0);
      check("drop_done", a_done, 4'b0100);
      step();
      check("drop_idle", a_st, ST_IDLE);
      check("drop_ram200", mem_a[200], SPR_DOT);

      // async reset during RESP
      do_reset();
      preload(1'b0, 9'd50, SPR_WALL);
      a_addr[0*AW +: AW] = 9'd50;
      a_wdata[0*DW +: DW] = SPR_GHOST;
      a_wen = 4'b0001;
      a_req = 4'b0001;
      step();
      step();
      step();
      check("ar_resp", a_rv, 1);
      rst = 1'b1;
      #1;
      check("ar_grant", a_grant, 0);
      check("ar_rvalid", a_rv, 0);
      check("ar_rdata", a_rdata, 0);
      check("ar_done", a_done, 0);
      check("ar_map_write", a_mw, 0);
      check("ar_addr", a_maddr, 0);
      check("ar_state", a_st, ST_IDLE);
      #1;
      rst = 1'b0;
      a_req = 4'b1000;
      a_addr[3*AW +: AW] = 9'd60;
      a_wdata[3*DW +: DW] = SPR_DOT;
      a_wen = 4'b1000;
      step();
      check("ar_regrant", a_grant, 4'b1000);
      check("ar_readdr", a_maddr, 60);
      step();
      step();
      step();
      check("ar_write", a_mw, 1);
      check("ar_waddr", a_maddr, 60);
      step();
      a_req = '0;
      check("ar_ram50", mem_a[50], SPR_WALL);
      check("ar_ram60", mem_a[60], SPR_DOT);

      // RD_LAT=3 instance
      preload(1'b1, 9'd300, SPR_WALL);
      b_addr[0*AW +: AW] = 9'd300;
      b_wdata[0*DW +: DW] = SPR_PACMAN;
      b_wen = 4'b0001;
      b_req = 4'b0001;
      step();  // t+1
      check("l3_map_read", b_mr, 1);
      check("l3_addr1", b_maddr, 300);
      for (int c = 2; c <= 4; c++) begin
         step();
         check($sformatf("l3_t%0d_read", c), b_mr, 0);
         check($sformatf("l3_t%0d_rv", c), b_rv, 0);
         check($sformatf("l3_t%0d_addr", c), b_maddr, 300);
      end
      step();  // t+5
      check("l3_rvalid", b_rv, 1);
      check("l3_rdata", b_rdata, SPR_WALL);
      check("l3_addr5", b_maddr, 300);
      step();  // t+6
      check("l3_map_write", b_mw, 1);
      check("l3_wdata", b_mdo, SPR_PACMAN);
      check("l3_addr6", b_maddr, 300);
      check("l3_done", b_done, 4'b0001);
      step();
      b_req = '0;
      check("l3_ram300", mem_b[300], SPR_PACMAN);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/map_access_arbiter.md
Name: map_access_arbiter

Overview:
- Shares the single-port map/sprite memory between character controllers (Pacman, ghosts) that each need an atomic read-modify-write of one map cell.
- Replaces the free-running read/write toggle with a granted, sequenced transaction: read cell, return data, accept write-back, then release.
- Sits between the character controllers and the map RAM in the top-level game datapath.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 is Pacman.
- ADDR_W, 9, map address width.
- DATA_W, 3, sprite code width.
- RD_LAT, 1, map RAM read latency in cycles; legal range 1..4.

Ports:
- clock_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request, level-sensitive.
- req_addr  in  NUM_REQ*ADDR_W  flattened cell addresses; slice i belongs to requester i.
- req_wdata  in  NUM_REQ*DATA_W  flattened write-back sprite codes.
- req_wen  in  NUM_REQ  requester wants the write-back performed.
- grant  out  NUM_REQ  one-hot; held for the whole transaction.
- rdata  out  DATA_W  registered read data, broadcast to all requesters.
- rdata_valid  out  1  one-cycle pulse; rdata is valid for the granted requester.
- done  out  NUM_REQ  one-hot, one-cycle pulse at transaction end.
- map_address  out  ADDR_W  RAM address.
- map_read  out  1  RAM read strobe.
- map_write  out  1  RAM write strobe.
- map_data_out  out  DATA_W  RAM write data.
- map_data_in  in  DATA_W  RAM read data.

Behaviour:
- Reset (async, active-high): state IDLE; rr pointer 0; all outputs 0; latched index and address 0. Asserting reset mid-transaction aborts it; no map_write is issued.
- FSM states: IDLE, READ, WAIT, RESP, WRITE.
- IDLE: if any req bit is set, pick the first set bit searching from ptr upward with wrap. Register the winner index and its req_addr slice. Set ptr = winner+1 mod NUM_REQ, then go to READ. If no req bit is set, stay in IDLE.
- READ, 1 cycle: grant[idx]=1; map_address=latched address; map_read=1. Go to WAIT.
- WAIT, RD_LAT cycles, counted down: map_read=0, map_address held. On the last WAIT cycle, register map_data_in into rdata. Go to RESP.
- RESP, 1 cycle: rdata_valid=1. Go to WRITE.
- WRITE, 1 cycle: sample req_wen[idx], req_wdata slice and req[idx].
  - map_write = req_wen[idx] AND req[idx].
  - map_data_out = req_wdata slice; map_address = latched address.
  - done[idx]=1. Go to IDLE.
- grant is 1 from READ through WRITE inclusive, and 0 in IDLE.
- Transaction length is RD_LAT+3 cycles in the granted states, plus 1 IDLE arbitration cycle. With RD_LAT=1: request sampled at cycle t, map_read at t+1, rdata_valid at t+3, map_write/done at t+4.
- req_addr changes after latching are ignored.
- If req drops mid-transaction, the sequence still completes, but the write is suppressed (map_write=0). done still pulses.
- Requests arriving during a transaction wait; they are arbitrated at the next IDLE cycle.
- A requester holding req high continuously gets at most one transaction per round when others are requesting.
- NUM_REQ=1 is legal: ptr stays 0.
- map_write and map_read are never asserted in the same cycle.

Decomposition:
- Shared package map_pkg:
  - ADDR_W and DATA_W defaults.
  - Sprite code constants: EMPTY=0, WALL=1, DOT=2, PACMAN=3, GHOST=4.
  - FSM state encoding constants.
- One sub-module, rr_priority_picker: combinational round-robin search (req, ptr) -> one-hot winner + index + any.

Test Plan:
- Single access: req=0001, addr0=9'd37, RAM[37]=2, wen0=1, wdata0=3 → map_read at t+1 with address 37; rdata=2 with rdata_valid at t+3; map_write with data 3 at t+4; done=0001; RAM[37]=3.
- Contention: req=1111 held high → grants in order 0,1,2,3,0; each grant lasts exactly 4 cycles, separated by 1 IDLE cycle.
- Read-only: wen1=0 → rdata_valid pulses, map_write stays 0, done=0010.
- Dropout: requester 2 deasserts req during WAIT with wen2=1 → no map_write; done=0100; arbiter back in IDLE the next cycle.
- Async reset asserted during RESP → all outputs 0 immediately, before the next clock edge; after release, req=1000 is granted first (ptr=0 search) with no stale write.
- RD_LAT=3: map_read at t+1, rdata_valid at t+5, map_write at t+6; address is held stable from t+1 to t+6.
